leaf_arb2: RTL

Two-to-one leaf arbiter that merges the outbound packet streams of two page leaf interfaces onto a single BFT leaf input port. Each requester gets a small ingress FIFO; a round-robin scheduler with a burst limit selects packets into a registered output stage that honours downstream backpressure. A resend request replays the last emitted packet. The block sits between a page pair and its shared BFT leaf.

---
 rtl/leaf_arb2_pkg.sv | 14 +
 rtl/leaf_arb2_if.sv | 25 ++
 rtl/leaf_arb2_fifo.sv | 62 ++++++
 rtl/leaf_arb2.sv | 144 ++++++++++++++
 4 files changed

// File: rtl/leaf_arb2_pkg.sv
// Shared types for the two-to-one leaf arbiter: packet type, valid-bit index, port index.
package leaf_arb_pkg;

  localparam int PKT_W     = 49;
  localparam int VALID_BIT = PKT_W - 1;

  typedef logic [PKT_W-1:0] pkt_t;
  typedef logic             port_t;

  function automatic logic pkt_valid(input pkt_t p);
    return p[VALID_BIT];
  endfunction

endpackage

// File: rtl/leaf_arb2_if.sv
// Page-side and BFT-side signals of the leaf arbiter; slave is the arbiter, master drives it.
interface leaf_arb2_if;
  import leaf_arb_pkg::*;

  pkt_t       din_0;
  pkt_t       din_1;
  logic       full_0;
  logic       full_1;
  pkt_t       dout;
  port_t      dout_src;
  logic       ready;
  logic       resend;
  logic [1:0] overflow;

  modport master (
    output din_0, din_1, ready, resend,
    input  full_0, full_1, dout, dout_src, overflow
  );

  modport slave (
    input  din_0, din_1, ready, resend,
    output full_0, full_1, dout, dout_src, overflow
  );

endinterface

// File: rtl/leaf_arb2_fifo.sv
// leaf_fifo: single-clock ingress FIFO with count and registered full flag.
// A write at the same edge as a read always succeeds, even when full.
module leaf_fifo
  import leaf_arb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic clk,
  input  logic reset_n,
  input  pkt_t wr_data,
  input  logic rd,
  output pkt_t rd_data,
  output logic empty,
  output logic full,
  output logic drop
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  pkt_t           mem [DEPTH];
  logic [AW-1:0]  wr_ptr;
  logic [AW-1:0]  rd_ptr;
  logic [CW-1:0]  count;
  logic [CW-1:0]  count_next;
  logic           wr_req;
  logic           wr;

  assign wr_req  = pkt_valid(wr_data);
  assign wr      = wr_req && (!full || rd);
  assign drop    = wr_req && full && !rd;
  assign empty   = (count == '0);
  assign rd_data = mem[rd_ptr];

  always_comb begin
    count_next = count;
    case ({wr, rd})
      2'b10:   count_next = count + 1'b1;
      2'b01:   count_next = count - 1'b1;
      default: count_next = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (wr) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      full   <= 1'b0;
    end else begin
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count_next;
      full  <= (count_next == CW'(DEPTH));
    end
  end

endmodule

// File: rtl/leaf_arb2.sv
// leaf_arb2: merges two page packet streams onto one BFT leaf port with burst-limited
// round-robin, registered output, backpressure and single-packet replay. Macro: LEAF_ARB2_STATS_EN.
module leaf_arb2
  import leaf_arb_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_BURST  = 8
) (
  input  logic        clk,
  input  logic        reset_n,
  leaf_arb2_if.slave  bus
`ifdef LEAF_ARB2_STATS_EN
  ,
  output logic [31:0] pkt_cnt_0,
  output logic [31:0] pkt_cnt_1,
  output logic [15:0] drop_cnt
`endif
);

  localparam int BC_W = $clog2(MAX_BURST) + 1;
  localparam logic [BC_W-1:0] BC_MAX = BC_W'(MAX_BURST);

  pkt_t            head_0, head_1;
  logic            empty_0, empty_1;
  logic            drop_0, drop_1;
  logic            rd_0, rd_1;

  pkt_t            dout_q;
  port_t           src_q;
  pkt_t            last_pkt;
  port_t           last_src;
  logic            resend_pend;
  port_t           g;
  logic [BC_W-1:0] bc;
  logic [1:0]      overflow_q;

  logic            load;
  logic            accept;
  logic            resend_req;
  logic            gnt_valid;
  port_t           gnt;
  logic            take;

  leaf_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_0 (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_data (bus.din_0),
    .rd      (rd_0),
    .rd_data (head_0),
    .empty   (empty_0),
    .full    (bus.full_0),
    .drop    (drop_0)
  );

  leaf_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo_1 (
    .clk     (clk),
    .reset_n (reset_n),
    .wr_data (bus.din_1),
    .rd      (rd_1),
    .rd_data (head_1),
    .empty   (empty_1),
    .full    (bus.full_1),
    .drop    (drop_1)
  );

  assign load       = !pkt_valid(dout_q) || bus.ready;
  assign accept     = pkt_valid(dout_q) && bus.ready;
  assign resend_req = bus.resend || resend_pend;

  always_comb begin
    gnt_valid = !empty_0 || !empty_1;
    gnt       = 1'b0;
    if (!empty_0 && !empty_1) begin
      // bc is zero only before the first grant, so that tie goes to ~g (port 0)
      gnt = (bc != '0 && bc < BC_MAX) ? g : ~g;
    end else if (!empty_1) begin
      gnt = 1'b1;
    end
  end

  assign take = load && !resend_req && gnt_valid;
  assign rd_0 = take && (gnt == 1'b0);
  assign rd_1 = take && (gnt == 1'b1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dout_q      <= '0;
      src_q       <= 1'b0;
      last_pkt    <= '0;
      last_src    <= 1'b0;
      resend_pend <= 1'b0;
      g           <= 1'b1;
      bc          <= '0;
      overflow_q  <= 2'b00;
    end else begin
      overflow_q <= overflow_q | {drop_1, drop_0};
      if (accept) begin
        last_pkt <= dout_q;
        last_src <= src_q;
      end
      if (load) begin
        if (resend_req) begin
          // Before any acceptance last_pkt is all zeros, so the replay emits nothing
          dout_q      <= last_pkt;
          src_q       <= last_src;
          resend_pend <= 1'b0;
        end else if (gnt_valid) begin
          dout_q <= gnt ? head_1 : head_0;
          src_q  <= gnt;
          g      <= gnt;
          if (gnt == g) bc <= (bc == BC_MAX) ? bc : bc + 1'b1;
          else          bc <= BC_W'(1);
        end else begin
          dout_q <= '0;
          src_q  <= 1'b0;
        end
      end else if (bus.resend) begin
        resend_pend <= 1'b1;
      end
    end
  end

  assign bus.dout     = dout_q;
  assign bus.dout_src = src_q;
  assign bus.overflow = overflow_q;

`ifdef LEAF_ARB2_STATS_EN
  logic [16:0] drop_sum;
  assign drop_sum = {1'b0, drop_cnt} + 17'(drop_0) + 17'(drop_1);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pkt_cnt_0 <= '0;
      pkt_cnt_1 <= '0;
      drop_cnt  <= '0;
    end else begin
      if (accept && !src_q) pkt_cnt_0 <= pkt_cnt_0 + 1'b1;
      if (accept &&  src_q) pkt_cnt_1 <= pkt_cnt_1 + 1'b1;
      drop_cnt <= drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end
  end
`endif

endmodule
